// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: UART-fed subtractive GCD engine; shows operands on 7-seg, result on LEDs and echoes it over UART.
// Optional DISPLAY_SWITCH_EN: switch[7]=1 shows result on digi4/digi3 and switch value on digi2/digi1.
module single_cycle_cpu #(
   parameter int clks_per_bit = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] switch,
   output logic [6:0] digi1,
   output logic [6:0] digi2,
   output logic [6:0] digi3,
   output logic [6:0] digi4,
   output logic [7:0] led,
   output logic       txd,
   input  logic       rxd
);
   localparam int cw = $clog2(clks_per_bit);
   localparam logic [cw-1:0] bit_end = cw'(clks_per_bit - 1);
   localparam logic [cw-1:0] half_end = cw'(clks_per_bit / 2 - 1);
   typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SEND} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
   state_t state, state_nx;
   rx_t rx_st;
   logic [1:0] rxd_sy;
   logic rxd_q, rx_valid, rx_set, tx_busy, tx_done, tx_go, ld_a, ld_b, calc_done;
   logic [cw-1:0] rx_cnt, tx_cnt;
   logic [2:0] rx_bit;
   logic [3:0] tx_bit;
   logic [7:0] rx_sh, hold, a, b, ga, gb, result, gcd;
   logic [8:0] tx_sh;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'ha: hex7 = 7'b0001000;
         4'hb: hex7 = 7'b0000011;
         4'hc: hex7 = 7'b1000110;
         4'hd: hex7 = 7'b0100001;
         4'he: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // rxd_q holds the previous synchronized sample for start-edge detection
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rxd_sy <= 2'b11;
         rxd_q <= 1'b1;
      end else begin
         rxd_sy <= {rxd_sy[0], rxd};
         rxd_q <= rxd_sy[1];
      end

   assign rx_set = rx_st == RX_STOP && rx_cnt == bit_end && rxd_sy[1];

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_st <= RX_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh <= '0;
      end else begin
         case (rx_st)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (rxd_q && !rxd_sy[1]) rx_st <= RX_START;
            end
            RX_START:
               if (rx_cnt == half_end) begin
                  rx_cnt <= '0;
                  rx_st <= rxd_sy[1] ? RX_IDLE : RX_DATA;
               end else rx_cnt <= rx_cnt + 1'b1;
            RX_DATA:
               if (rx_cnt == bit_end) begin
                  rx_cnt <= '0;
                  rx_sh <= {rxd_sy[1], rx_sh[7:1]};
                  rx_bit <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_st <= RX_STOP;
               end else rx_cnt <= rx_cnt + 1'b1;
            default:
               if (rx_cnt == bit_end) rx_st <= RX_IDLE;
               else rx_cnt <= rx_cnt + 1'b1;
         endcase
      end

   // a fresh byte wins over a same-cycle consume so nothing is dropped
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         hold <= '0;
         rx_valid <= 1'b0;
      end else if (rx_set) begin
         hold <= rx_sh;
         rx_valid <= 1'b1;
      end else if (ld_a || ld_b) rx_valid <= 1'b0;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= WAIT_A;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_A: if (rx_valid) state_nx = WAIT_B;
         WAIT_B: if (rx_valid) state_nx = CALC;
         CALC: if (calc_done) state_nx = SEND;
         default: if (tx_done) state_nx = WAIT_A;
      endcase
   end

   always_comb begin
      ld_a = state == WAIT_A && rx_valid;
      ld_b = state == WAIT_B && rx_valid;
      tx_go = state == CALC && calc_done;
   end

   assign calc_done = ga == 8'd0 || gb == 8'd0 || ga == gb;
   assign gcd = ga == 8'd0 ? gb : ga;

   always_ff @(posedge clk or negedge reset)
      if (!reset) {a, b, ga, gb, result} <= '0;
      else begin
         if (ld_a) a <= hold;
         if (ld_b) begin
            b <= hold;
            ga <= a;
            gb <= hold;
         end else if (state == CALC && !calc_done) begin
            if (ga > gb) ga <= ga - gb;
            else gb <= gb - ga;
         end
         if (tx_go) result <= gcd;
      end

   assign led = result;
   assign tx_done = tx_busy && tx_cnt == bit_end && tx_bit == 4'd9;

   // tx_sh holds the data bits still to send followed by the stop bit
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tx_busy <= 1'b0;
         txd <= 1'b1;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh <= '1;
      end else if (tx_go) begin
         tx_busy <= 1'b1;
         txd <= 1'b0;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh <= {1'b1, gcd};
      end else if (tx_busy) begin
         if (tx_cnt != bit_end) tx_cnt <= tx_cnt + 1'b1;
         else begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 4'd1;
            txd <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[8:1]};
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
               txd <= 1'b1;
            end
         end
      end

`ifdef DISPLAY_SWITCH_EN
   logic [7:0] sw_s1, sw_s2;
   always_ff @(posedge clk or negedge reset)
      if (!reset) {sw_s1, sw_s2} <= '0;
      else begin
         sw_s1 <= switch;
         sw_s2 <= sw_s1;
      end
   assign digi4 = hex7(sw_s2[7] ? result[7:4] : a[7:4]);
   assign digi3 = hex7(sw_s2[7] ? result[3:0] : a[3:0]);
   assign digi2 = hex7(sw_s2[7] ? sw_s2[7:4] : b[7:4]);
   assign digi1 = hex7(sw_s2[7] ? sw_s2[3:0] : b[3:0]);
`else
   assign digi4 = hex7(a[7:4]);
   assign digi3 = hex7(a[3:0]);
   assign digi2 = hex7(b[7:4]);
   assign digi1 = hex7(b[3:0]);
`endif
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: drives UART operand pairs, decodes the UART result frames against a queue of expected GCDs.
// Runs the DUT with a short bit period so several full transactions fit in a short run.
module tb_single_cycle_cpu;
   localparam int cpb = 16;
   localparam int bit_t = cpb * 20;
   logic clk = 1'b0, reset = 1'b1, txd, rxd = 1'b1;
   logic [7:0] switch = 8'h00, led;
   logic [6:0] digi1, digi2, digi3, digi4;
   logic [7:0] sb[$];
   int tests = 0, fails = 0, seen = 0, nexp = 0;
   logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   single_cycle_cpu #(.clks_per_bit(cpb)) dut (
      .clk(clk), .reset(reset), .switch(switch), .digi1(digi1), .digi2(digi2),
      .digi3(digi3), .digi4(digi4), .led(led), .txd(txd), .rxd(rxd)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gcd_ref(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check_disp(input string tag, input logic [7:0] hi, input logic [7:0] lo);
      check({tag, "_d4"}, {25'd0, digi4}, {25'd0, seg[hi[7:4]]});
      check({tag, "_d3"}, {25'd0, digi3}, {25'd0, seg[hi[3:0]]});
      check({tag, "_d2"}, {25'd0, digi2}, {25'd0, seg[lo[7:4]]});
      check({tag, "_d1"}, {25'd0, digi1}, {25'd0, seg[lo[3:0]]});
   endtask

   task automatic send_byte(input logic [7:0] v, input logic stop);
      rxd = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rxd = v[i];
         #(bit_t);
      end
      rxd = stop;
      #(bit_t);
      rxd = 1'b1;
   endtask

   task automatic wait_frames(input string tag);
      for (int i = 0; i < 4000 && seen < nexp; i++) @(negedge clk);
      check({tag, "_frames"}, seen, nexp);
   endtask

   task automatic run_pair(input string tag, input logic [7:0] x, input logic [7:0] y);
      send_byte(x, 1'b1);
      send_byte(y, 1'b1);
      sb.push_back(gcd_ref(x, y));
      nexp++;
      check_disp(tag, x, y);
      wait_frames(tag);
      check({tag, "_led"}, {24'd0, led}, {24'd0, gcd_ref(x, y)});
   endtask

   // UART frame decoder sampling mid-bit, away from clock edges
   initial begin
      logic st, sp;
      logic [7:0] v;
      logic [31:0] exp;
      forever begin
         @(negedge txd);
         #(bit_t / 2 + 10);
         st = txd;
         for (int i = 0; i < 8; i++) begin
            #(bit_t);
            v[i] = txd;
         end
         #(bit_t);
         sp = txd;
         exp = sb.size() > 0 ? {24'd0, sb.pop_front()} : 32'hdead_beef;
         check("tx_start", {31'd0, st}, 32'd0);
         check("tx_stop", {31'd0, sp}, 32'd1);
         check("tx_byte", {24'd0, v}, exp);
         seen++;
      end
   end

   initial begin
      #2 reset = 1'b0;
      #13;
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_led", {24'd0, led}, 32'd0);
      check_disp("rst", 8'h00, 8'h00);
      #7 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_txd", {31'd0, txd}, 32'd1);
      check_disp("post_rst", 8'h00, 8'h00);
      run_pair("p01", 8'h01, 8'h01);
      run_pair("p24", 8'h24, 8'h3C);
      run_pair("p00_07", 8'h00, 8'h07);
      run_pair("p00_00", 8'h00, 8'h00);
      run_pair("pff_01", 8'hFF, 8'h01);
      run_pair("pc8_4b", 8'hC8, 8'h4B);
      send_byte(8'h55, 1'b0);
      repeat (20) @(negedge clk);
      check_disp("bad_stop", 8'hC8, 8'h4B);
      run_pair("p12_18", 8'h12, 8'h18);
      switch = 8'b01001010;
      repeat (4) @(negedge clk);
      check_disp("sw4a", 8'h12, 8'h18);
      switch = 8'hCA;
      repeat (4) @(negedge clk);
`ifdef DISPLAY_SWITCH_EN
      check_disp("swca", 8'h06, 8'hCA);
`else
      check_disp("swca", 8'h12, 8'h18);
`endif
      switch = 8'h00;
      rxd = 1'b0;
      #(bit_t * 4);
      reset = 1'b0;
      #5;
      check("midrx_txd", {31'd0, txd}, 32'd1);
      check("midrx_led", {24'd0, led}, 32'd0);
      check_disp("midrx", 8'h00, 8'h00);
      #15 reset = 1'b1;
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      run_pair("p36_24", 8'h36, 8'h24);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      sb.push_back(8'h01);
      nexp++;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      sb.push_back(8'h01);
      nexp++;
      check_disp("stream", 8'h01, 8'h02);
      wait_frames("stream");
      check("stream_led", {24'd0, led}, 32'd1);
      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
